div_share_sched: RTL and testbench

Round-robin scheduler that shares one serial divider (start-pulse / done interface) between NUM_REQ requesters, e.g. the cycles-per-bitflip and bitflip-density computations of several scrub monitors. It accepts one operand pair at a time, sequences the divider's single-cycle start, and waits for done with a watchdog. It returns the quotient to the granted requester and handles divide-by-zero without invoking the divider. It sits between the monitor register interfaces and a single divider instance.

---
 rtl/div_share_sched.sv | 126 ++++++++++++
 tb/tb_div_share_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/div_share_sched.sv
// div_share_sched: round-robin arbiter sharing one start/done serial divider among NUM_REQ requesters
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   req_valid_i/req_ready_o  per-requester request, one-cycle accept pulse
//   req_a_i/req_b_i          packed dividends/divisors, requester k at [k*N +: N]
//   resp_valid_o             one-cycle result pulse to the granted requester
//   resp_quot_o/resp_err_o   quotient and {timeout, div_by_zero}, held until the next response
//   div_start_o/div_a_o/div_b_o/div_done_i/div_quot_i  shared divider handshake
//   busy_o                   high whenever a request is in flight
//   timeout_cnt_o            saturating count of watchdog aborts
module div_share_sched #(
   parameter int NUM_REQ = 4,
   parameter int N = 32,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   input  logic [NUM_REQ*N-1:0] req_a_i,
   input  logic [NUM_REQ*N-1:0] req_b_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   output logic [NUM_REQ-1:0]   resp_valid_o,
   output logic [N-1:0]         resp_quot_o,
   output logic [1:0]           resp_err_o,
   output logic                 div_start_o,
   output logic [N-1:0]         div_a_o,
   output logic [N-1:0]         div_b_o,
   input  logic                 div_done_i,
   input  logic [N-1:0]         div_quot_i,
   output logic                 busy_o,
   output logic [15:0]          timeout_cnt_o
);
   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
   state_t state, state_n;
   logic [GW-1:0] ptr, gnt, sel, idx;
   logic [N-1:0] a_q, b_q, quot_q, a_sel, b_sel;
   logic [1:0] err_q;
   logic [WW-1:0] wd, wd_inc;
   logic [15:0] tcnt;
   logic any_req, wd_exp;
   assign any_req = |req_valid_i;
   assign a_sel = req_a_i[sel*N +: N];
   assign b_sel = req_b_i[sel*N +: N];
   assign wd_inc = wd + 1'b1;
   // the abort decision uses the post-increment count so WAIT lasts at most TIMEOUT-1 cycles
   assign wd_exp = wd_inc == WW'(TIMEOUT - 1);
   assign div_a_o = a_q;
   assign div_b_o = b_q;
   assign resp_quot_o = quot_q;
   assign resp_err_o = err_q;
   assign busy_o = state != IDLE;
   assign timeout_cnt_o = tcnt;
   // scan downward so the requester closest after the last grant wins
   always_comb begin
      sel = '0;
      idx = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = GW'((int'(ptr) + i) % NUM_REQ);
         if (req_valid_i[idx]) sel = idx;
      end
   end
   always_comb begin
      state_n = state;
      req_ready_o = '0;
      resp_valid_o = '0;
      div_start_o = 1'b0;
      case (state)
         IDLE: begin
            // ready is combinational, so mask it while reset holds the FSM in IDLE
            if (any_req && !rst_i) begin
               req_ready_o = NUM_REQ'(1) << sel;
               state_n = (b_sel == '0) ? RESP : LAUNCH;
            end
         end
         LAUNCH: begin
            div_start_o = 1'b1;
            state_n = WAIT;
         end
         WAIT: state_n = (div_done_i || wd_exp) ? RESP : WAIT;
         RESP: begin
            resp_valid_o = NUM_REQ'(1) << gnt;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         ptr <= GW'(NUM_REQ - 1);
         gnt <= '0;
         a_q <= '0;
         b_q <= '0;
         quot_q <= '0;
         err_q <= '0;
         wd <= '0;
         tcnt <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && any_req) begin
            gnt <= sel;
            a_q <= a_sel;
            b_q <= b_sel;
            if (b_sel == '0) begin
               quot_q <= '1;
               err_q <= 2'b01;
            end
         end
         if (state == LAUNCH) wd <= '0;
         if (state == WAIT) begin
            wd <= wd_inc;
            if (div_done_i) begin
               quot_q <= div_quot_i;
               err_q <= 2'b00;
            end else if (wd_exp) begin
               quot_q <= '0;
               err_q <= 2'b10;
               if (tcnt != '1) tcnt <= tcnt + 1'b1;
            end
         end
         if (state == RESP) ptr <= gnt;
      end
   end
endmodule

// File: tb/tb_div_share_sched.sv
// tb_div_share_sched: randomized self-checking bench with a transaction-level scheduler/divider model
module tb_div_share_sched;
   localparam int NR = 4;
   localparam int N = 32;
   localparam int TO = 64;
   logic clk = 1'b0;
   logic rst_i;
   logic [NR-1:0] req_valid_i;
   logic [NR*N-1:0] req_a_i, req_b_i;
   logic [NR-1:0] req_ready_o, resp_valid_o;
   logic [N-1:0] resp_quot_o, div_a_o, div_b_o, div_quot_i;
   logic [1:0] resp_err_o;
   logic div_start_o, div_done_i, busy_o;
   logic [15:0] timeout_cnt_o;
   int checks = 0;
   int errors = 0;
   int ptr_m, tcnt_m;
   logic [N-1:0] last_q;
   logic [1:0] last_e;
   logic [N-1:0] a_v [NR];
   logic [N-1:0] b_v [NR];
   div_share_sched #(.NUM_REQ(NR), .N(N), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i),
      .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o), .resp_quot_o(resp_quot_o),
      .resp_err_o(resp_err_o), .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
      .div_done_i(div_done_i), .div_quot_i(div_quot_i), .busy_o(busy_o), .timeout_cnt_o(timeout_cnt_o)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic drive_ops();
      for (int k = 0; k < NR; k++) begin
         req_a_i[k*N +: N] = a_v[k];
         req_b_i[k*N +: N] = b_v[k];
      end
   endtask
   task automatic rand_ops();
      for (int k = 0; k < NR; k++) begin
         a_v[k] = $urandom;
         b_v[k] = ($urandom_range(0, 5) == 0) ? '0 : ($urandom_range(0, 1) ? N'($urandom) : N'($urandom_range(1, 1000)));
      end
   endtask
   task automatic model_reset();
      ptr_m = NR - 1;
      tcnt_m = 0;
      last_q = '0;
      last_e = '0;
   endtask
   // d = cycles from start to done (1..TO-1); d = 0 means the divider never answers
   task automatic txn(input logic [NR-1:0] mask, input int d);
      logic [NR-1:0] oh;
      logic [N-1:0] a, b, q;
      logic [1:0] e;
      int g, off;
      bit real_done;
      @(negedge clk);
      req_valid_i = mask;
      drive_ops();
      div_done_i = 1'($urandom_range(0, 1));
      div_quot_i = $urandom;
      #1;
      g = -1;
      for (int i = 1; i <= NR; i++) if (g < 0 && mask[(ptr_m + i) % NR]) g = (ptr_m + i) % NR;
      oh = '0;
      oh[g] = 1'b1;
      check("ready", req_ready_o, oh);
      check("idle_busy", busy_o, 0);
      check("hold_quot", resp_quot_o, last_q);
      check("hold_err", resp_err_o, last_e);
      a = a_v[g];
      b = b_v[g];
      if (b == 0) begin
         off = 1; q = '1; e = 2'b01;
      end else if (d == 0) begin
         off = TO + 1; q = '0; e = 2'b10;
         if (tcnt_m < 65535) tcnt_m++;
      end else begin
         off = d + 2; q = a / b; e = 2'b00;
      end
      for (int c = 1; c <= off; c++) begin
         @(negedge clk);
         req_valid_i = NR'($urandom);
         for (int k = 0; k < NR; k++) begin
            req_a_i[k*N +: N] = $urandom;
            req_b_i[k*N +: N] = $urandom;
         end
         real_done = b != 0 && d != 0 && c == d + 1;
         div_done_i = real_done ? 1'b1 : ((c == 1 || c == off) ? 1'($urandom_range(0, 1)) : 1'b0);
         div_quot_i = real_done ? a / b : N'($urandom);
         #1;
         if (c < off) begin
            check("busy", busy_o, 1);
            check("resp_early", resp_valid_o, 0);
            check("ready_busy", req_ready_o, 0);
            check("start", div_start_o, c == 1);
            check("div_a", div_a_o, a);
            check("div_b", div_b_o, b);
         end else begin
            check("resp_valid", resp_valid_o, oh);
            check("resp_quot", resp_quot_o, q);
            check("resp_err", resp_err_o, e);
            check("resp_start", div_start_o, 0);
            check("resp_busy", busy_o, 1);
            check("tcnt", timeout_cnt_o, tcnt_m);
         end
      end
      ptr_m = g;
      last_q = q;
      last_e = e;
   endtask
   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_start"}, div_start_o, 0);
      check({tag, "_div_a"}, div_a_o, 0);
      check({tag, "_div_b"}, div_b_o, 0);
      check({tag, "_resp"}, resp_valid_o, 0);
      check({tag, "_ready"}, req_ready_o, 0);
      check({tag, "_quot"}, resp_quot_o, 0);
      check({tag, "_err"}, resp_err_o, 0);
      check({tag, "_tcnt"}, timeout_cnt_o, 0);
   endtask
   initial begin
      rst_i = 1'b1;
      req_valid_i = '1;
      div_done_i = 1'b0;
      div_quot_i = '0;
      rand_ops();
      drive_ops();
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      rst_i = 1'b0;
      req_valid_i = '0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         rand_ops();
         txn('1, $urandom_range(1, 10));
      end
      a_v[2] = 100; b_v[2] = 7;
      txn(4'b0100, 32);
      a_v[1] = 55; b_v[1] = 0;
      txn(4'b0010, 5);
      a_v[0] = 1000; b_v[0] = 3;
      txn(4'b0001, 0);
      a_v[3] = 999; b_v[3] = 10;
      txn(4'b1000, 10);
      a_v[0] = 77; b_v[0] = 5;
      txn(4'b0001, TO - 1);
      for (int k = 0; k < NR; k++) b_v[k] = N'($urandom_range(1, 50));
      @(negedge clk);
      req_valid_i = '1;
      drive_ops();
      div_done_i = 1'b0;
      repeat (6) @(negedge clk);
      rst_i = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      check("midrst_hold", resp_valid_o, 0);
      rst_i = 1'b0;
      req_valid_i = '0;
      model_reset();
      rand_ops();
      txn('1, 5);
      for (int i = 0; i < 30; i++) begin
         int r;
         rand_ops();
         r = $urandom_range(0, 9);
         txn(NR'($urandom_range(1, (1 << NR) - 1)), r == 0 ? 0 : (r == 1 ? TO - 1 : int'($urandom_range(1, 40))));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
